// File: rtl/beta_pkg.sv
// Shared definitions for the register file slice.
//
// Contents:
//   DATA_W / ADDR_W      register width and register address width
//   SB_CNT_W             width of each outstanding-load counter
//   NUM_REGS             number of physical registers (R0..R30)
//   REG_ZERO             address of the hardwired zero register (R31)
//   word_t / addr_t      data and address types
//   sb_op_t / sb_op()    collapses a counter's inc/dec pair into one action
package beta_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int SB_CNT_W = 2;
    localparam int NUM_REGS = 31;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd31;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_INC  = 2'd1,
        SB_DEC  = 2'd2
    } sb_op_t;

    // An issue and a retire hitting the same register cancel out, so
    // both-set and neither-set map to the same hold action.
    function automatic sb_op_t sb_op(input logic inc, input logic dec);
        if (inc && !dec) begin
            return SB_INC;
        end
        if (dec && !inc) begin
            return SB_DEC;
        end
        return SB_HOLD;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write-back bus into the register file.
//
// Signals:
//   rf_w_addr  destination register of the write-back
//   rf_w_data  value being written back
//   rf_we      write enable
//   rf_w_ld    the write is the result of a LD/LDR (retires a scoreboard entry)
//
// Modports:
//   master     write-back stage (drives everything)
//   slave      register file (receives everything)
interface reg_file_if;
    import beta_pkg::*;

    addr_t rf_w_addr;
    word_t rf_w_data;
    logic  rf_we;
    logic  rf_w_ld;

    modport master (
        output rf_w_addr,
        output rf_w_data,
        output rf_we,
        output rf_w_ld
    );

    modport slave (
        input rf_w_addr,
        input rf_w_data,
        input rf_we,
        input rf_w_ld
    );

endinterface

// File: rtl/rf_sb_counter.sv
// One outstanding-load counter of the register file scoreboard.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         a load targeting this register was issued
//   dec         a load result for this register was written back
//   cnt         number of loads still in flight
//   nonzero     cnt != 0
//   err         sticky: an increment at max or a decrement at zero was seen
//
// The counter saturates instead of wrapping so that a misbehaving pipeline
// cannot make a busy register look free (or the reverse); err records it.
module rf_sb_counter
    import beta_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    output logic [SB_CNT_W-1:0] cnt,
    output logic                nonzero,
    output logic                err
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            case (sb_op(inc, dec))
                SB_INC: begin
                    if (cnt == CNT_MAX) begin
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt + SB_CNT_W'(1);
                    end
                end
                SB_DEC: begin
                    if (cnt == '0) begin
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt - SB_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign nonzero = |cnt;

endmodule

// File: rtl/reg_file.sv
// Register file feeding decode, written by the write-back stage.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ra_addr/ra_data   read port A (combinational)
//   ra_busy           register on port A still has a load in flight
//   rb_addr/rb_data   read port B (combinational)
//   rb_busy           register on port B still has a load in flight
//   wb                write-back bus (reg_file_if.slave)
//   pend_set          decode issues a LD/LDR this cycle
//   pend_addr         destination register of that load
//   sb_err            sticky scoreboard over/underflow flag
//
// R31 reads as zero, ignores writes and is never tracked by the scoreboard.
module reg_file
    import beta_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  addr_t      ra_addr,
    output word_t      ra_data,
    output logic       ra_busy,
    input  addr_t      rb_addr,
    output word_t      rb_data,
    output logic       rb_busy,
    reg_file_if.slave  wb,
    input  logic       pend_set,
    input  addr_t      pend_addr,
    output logic       sb_err
);

    word_t regs [NUM_REGS];

    logic                inc_en;
    logic                dec_en;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] nonzero_vec;
    logic [NUM_REGS-1:0] err_vec;
    logic [NUM_REGS-1:0] busy_vec;
    logic [SB_CNT_W-1:0] cnt_vec [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb.rf_we && (wb.rf_w_addr != REG_ZERO)) begin
            regs[wb.rf_w_addr] <= wb.rf_w_data;
        end
    end

    assign inc_en = pend_set && (pend_addr != REG_ZERO);
    assign dec_en = wb.rf_we && wb.rf_w_ld && (wb.rf_w_addr != REG_ZERO);

    // A register whose last outstanding load is being written back right
    // now is released in the same cycle; the consumer picks the value up
    // through the bypass. A fresh issue to the same register keeps it busy.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
        assign inc_vec[i] = inc_en && (pend_addr == addr_t'(i));
        assign dec_vec[i] = dec_en && (wb.rf_w_addr == addr_t'(i));

        rf_sb_counter u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc_vec[i]),
            .dec     (dec_vec[i]),
            .cnt     (cnt_vec[i]),
            .nonzero (nonzero_vec[i]),
            .err     (err_vec[i])
        );

        assign busy_vec[i] = nonzero_vec[i] &&
                             !(dec_vec[i] && !inc_vec[i] && (cnt_vec[i] == SB_CNT_W'(1)));
    end

    assign sb_err = |err_vec;

    // Reads are forced to zero while reset is held so that a write-back
    // still on the bus cannot leak through the bypass.
    always_comb begin
        ra_data = '0;
        ra_busy = 1'b0;
        rb_data = '0;
        rb_busy = 1'b0;
        if (rst_n && (ra_addr != REG_ZERO)) begin
            ra_data = (wb.rf_we && (wb.rf_w_addr == ra_addr)) ? wb.rf_w_data : regs[ra_addr];
            ra_busy = busy_vec[ra_addr];
        end
        if (rst_n && (rb_addr != REG_ZERO)) begin
            rb_data = (wb.rf_we && (wb.rf_w_addr == rb_addr)) ? wb.rf_w_data : regs[rb_addr];
            rb_busy = busy_vec[rb_addr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
//
// A behavioural model (plain arrays of register values and integer load
// counts) tracks what the register file must hold; a compare process checks
// every output against it on each falling clock edge. Directed vectors with
// hand-computed expectations pin the model's behaviour as well.
module tb_reg_file;
    import beta_pkg::*;

    logic  clk;
    logic  rst_n;
    addr_t ra_addr;
    word_t ra_data;
    logic  ra_busy;
    addr_t rb_addr;
    word_t rb_data;
    logic  rb_busy;
    logic  pend_set;
    addr_t pend_addr;
    logic  sb_err;

    reg_file_if wb ();

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_addr   (ra_addr),
        .ra_data   (ra_data),
        .ra_busy   (ra_busy),
        .rb_addr   (rb_addr),
        .rb_data   (rb_data),
        .rb_busy   (rb_busy),
        .wb        (wb.slave),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .sb_err    (sb_err)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    logic [31:0] m_regs [31];
    int          m_cnt  [31];
    bit          m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit inc_to(input int r);
        return pend_set && (int'(pend_addr) == r);
    endfunction

    function automatic bit dec_to(input int r);
        return wb.rf_we && wb.rf_w_ld && (int'(wb.rf_w_addr) == r);
    endfunction

    function automatic int raw_cnt(input int r);
        return m_cnt[r] + int'(inc_to(r)) - int'(dec_to(r));
    endfunction

    function automatic logic [31:0] exp_data(input addr_t a);
        if (!rst_n || a == 5'd31) begin
            return 32'h0;
        end
        if (wb.rf_we && wb.rf_w_addr == a) begin
            return wb.rf_w_data;
        end
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input addr_t a);
        if (!rst_n || a == 5'd31) begin
            return 1'b0;
        end
        return (m_cnt[a] > 0) && !(dec_to(int'(a)) && m_cnt[a] == 1 && !inc_to(int'(a)));
    endfunction

    // Model state update: counts move by +1/-1 and clip to 0..3, any clip
    // raises the sticky error.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 31; r++) begin
                m_regs[r] <= 32'h0;
                m_cnt[r]  <= 0;
            end
            m_err <= 1'b0;
        end else begin
            for (int r = 0; r < 31; r++) begin
                if (raw_cnt(r) > 3) begin
                    m_cnt[r] <= 3;
                    m_err    <= 1'b1;
                end else if (raw_cnt(r) < 0) begin
                    m_cnt[r] <= 0;
                    m_err    <= 1'b1;
                end else begin
                    m_cnt[r] <= raw_cnt(r);
                end
            end
            if (wb.rf_we && wb.rf_w_addr != 5'd31) begin
                m_regs[wb.rf_w_addr] <= wb.rf_w_data;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("cyc_ra_data", ra_data, exp_data(ra_addr));
            check_output("cyc_rb_data", rb_data, exp_data(rb_addr));
            check_output("cyc_ra_busy", 32'(ra_busy), 32'(exp_busy(ra_addr)));
            check_output("cyc_rb_busy", 32'(rb_busy), 32'(exp_busy(rb_addr)));
            check_output("cyc_sb_err", 32'(sb_err), 32'(m_err));
        end
    end

    task automatic apply_stimulus(input logic we, input logic ld, input addr_t wa, input word_t wd,
                                  input logic ps, input addr_t pa, input addr_t ra, input addr_t rb);
        @(posedge clk);
        #1;
        wb.rf_we     = we;
        wb.rf_w_ld   = ld;
        wb.rf_w_addr = wa;
        wb.rf_w_data = wd;
        pend_set     = ps;
        pend_addr    = pa;
        ra_addr      = ra;
        rb_addr      = rb;
    endtask

    initial begin
        rst_n        = 1'b1;
        wb.rf_we     = 1'b0;
        wb.rf_w_ld   = 1'b0;
        wb.rf_w_addr = '0;
        wb.rf_w_data = '0;
        pend_set     = 1'b0;
        pend_addr    = '0;
        ra_addr      = '0;
        rb_addr      = '0;

        #2 rst_n = 1'b0;
        #1 check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write with same-cycle bypass, then stored value
        apply_stimulus(1, 0, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0);
        @(negedge clk);
        check_output("wr_bypass", ra_data, 32'hDEADBEEF);
        check_output("wr_other_zero", rb_data, 32'h0);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd0);
        @(negedge clk);
        check_output("wr_stored", ra_data, 32'hDEADBEEF);

        // Zero register: writes and load issues to R31 are ignored
        apply_stimulus(1, 0, 5'd31, 32'h1234, 1, 5'd31, 5'd5, 5'd31);
        @(negedge clk);
        check_output("zero_same", rb_data, 32'h0);
        check_output("zero_busy", 32'(rb_busy), 32'h0);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd31);
        @(negedge clk);
        check_output("zero_next", rb_data, 32'h0);
        check_output("zero_no_side", ra_data, 32'hDEADBEEF);
        check_output("zero_no_err", 32'(sb_err), 32'h0);

        // Load scoreboard on R7: busy after issue, released at write-back
        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd7, 5'd0);
        @(negedge clk);
        check_output("ld_issue_cycle", 32'(ra_busy), 32'h0);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0);
        @(negedge clk);
        check_output("ld_busy_next", 32'(ra_busy), 32'h1);
        apply_stimulus(1, 1, 5'd7, 32'hA5, 0, 5'd0, 5'd7, 5'd0);
        @(negedge clk);
        check_output("ld_release", 32'(ra_busy), 32'h0);
        check_output("ld_bypass", ra_data, 32'hA5);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0);
        @(negedge clk);
        check_output("ld_after", ra_data, 32'hA5);

        // Simultaneous issue and retire on R3 keeps the count at 1
        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd3, 5'd0, 5'd3);
        apply_stimulus(1, 1, 5'd3, 32'h33, 1, 5'd3, 5'd0, 5'd3);
        @(negedge clk);
        check_output("simul_busy", 32'(rb_busy), 32'h1);
        check_output("simul_bypass", rb_data, 32'h33);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd3);
        @(negedge clk);
        check_output("simul_after", 32'(rb_busy), 32'h1);
        apply_stimulus(1, 1, 5'd3, 32'h44, 0, 5'd0, 5'd0, 5'd3);
        @(negedge clk);
        check_output("simul_cnt_one", 32'(rb_busy), 32'h0);
        check_output("no_err_yet", 32'(sb_err), 32'h0);

        // Overflow on R9: four issues saturate the count at 3
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0);
        end
        @(negedge clk);
        check_output("ovf_before_edge", 32'(sb_err), 32'h0);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
        @(negedge clk);
        check_output("ovf_err", 32'(sb_err), 32'h1);
        check_output("ovf_busy", 32'(ra_busy), 32'h1);
        apply_stimulus(1, 1, 5'd9, 32'h91, 0, 5'd0, 5'd9, 5'd0);
        apply_stimulus(1, 1, 5'd9, 32'h92, 0, 5'd0, 5'd9, 5'd0);
        @(negedge clk);
        check_output("sat_two_left", 32'(ra_busy), 32'h1);
        apply_stimulus(1, 1, 5'd9, 32'h93, 0, 5'd0, 5'd9, 5'd0);
        @(negedge clk);
        check_output("sat_release", 32'(ra_busy), 32'h0);

        // Mid-cycle asynchronous reset with a write still on the bus
        apply_stimulus(1, 0, 5'd4, 32'hFFFFFFFF, 1, 5'd4, 5'd4, 5'd4);
        check_en = 1'b0;
        #2 rst_n = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra_addr = addr_t'(a);
            rb_addr = addr_t'(31 - a);
            #1;
            if (ra_data !== 32'h0 || rb_data !== 32'h0 || ra_busy !== 1'b0 || rb_busy !== 1'b0) begin
                check_output("rst_read_all", {ra_data[15:0], rb_data[13:0], ra_busy, rb_busy}, 32'h0);
            end else begin
                n_compared++;
            end
        end
        check_output("rst_sb_err", 32'(sb_err), 32'h0);
        wb.rf_we = 1'b0;
        pend_set = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_en = 1'b1;
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd7);
        @(negedge clk);
        check_output("rst_cleared_r5", ra_data, 32'h0);
        check_output("rst_cleared_r7", rb_data, 32'h0);

        // Underflow on R12: load write with nothing outstanding
        apply_stimulus(1, 1, 5'd12, 32'h12, 0, 5'd0, 5'd12, 5'd0);
        @(negedge clk);
        check_output("udf_busy", 32'(ra_busy), 32'h0);
        check_output("udf_before_edge", 32'(sb_err), 32'h0);
        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd12, 5'd12, 5'd13);
        @(negedge clk);
        check_output("udf_err", 32'(sb_err), 32'h1);
        check_output("udf_data", ra_data, 32'h12);
        check_output("udf_cnt_zero", 32'(ra_busy), 32'h0);

        // Issue to R13 while R12's single load retires: independent updates
        apply_stimulus(1, 1, 5'd12, 32'h120, 1, 5'd13, 5'd12, 5'd13);
        @(negedge clk);
        check_output("diff_release", 32'(ra_busy), 32'h0);
        check_output("diff_issue_cycle", 32'(rb_busy), 32'h0);
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd12, 5'd13);
        @(negedge clk);
        check_output("diff_r12_free", 32'(ra_busy), 32'h0);
        check_output("diff_r13_busy", 32'(rb_busy), 32'h1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register file on the receiving end of the write-back interface: rf_w_data, rf_w_addr, rf_we and the load flag.
- Feeds the decode stage through two combinational read ports.
- Write-through bypass for same-cycle read-after-write.
- Per-register load scoreboard; decode uses it to stall consumers of loads still in flight.
- R31 is the hardwired zero register.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
ZERO_REG, 31, address that reads as zero and ignores writes
SB_CNT_W, 2, width of each per-register outstanding-load counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ra_addr  input  ADDR_W  read port A address (Ra)
ra_data  output  DATA_W  read port A data
ra_busy  output  1  Ra has an outstanding load not yet written back
rb_addr  input  ADDR_W  read port B address (Rb, or Rc for ST)
rb_data  output  DATA_W  read port B data
rb_busy  output  1  Rb has an outstanding load
rf_w_addr  input  ADDR_W  write address from write-back stage
rf_w_data  input  DATA_W  write data from write-back stage
rf_we  input  1  write enable from write-back stage
rf_w_ld  input  1  current write is a LD/LDR result (op_ld_or_ldr from WB)
pend_set  input  1  decode issues a LD/LDR this cycle
pend_addr  input  ADDR_W  destination (Rc) of the issued load
sb_err  output  1  sticky scoreboard over/underflow flag

Behaviour:
- Reset: asynchronous on rst_n low. All 31 registers cleared to 0, all counters to 0, sb_err to 0. Mid-operation reset behaves the same; reads return 0 while rst_n is low.
- Storage: registers R0..R30. Write of rf_w_data to R[rf_w_addr] at posedge when rf_we=1 and rf_w_addr != ZERO_REG.
- Reads: combinational, zero latency.
  - Address ZERO_REG always returns 0.
  - Bypass: if rf_we=1 and rf_w_addr == read address != ZERO_REG, the port returns rf_w_data in the same cycle. Otherwise it returns stored R[addr].
  - Both ports are independent; both may bypass the same write simultaneously.
- Scoreboard: one SB_CNT_W-bit counter per register R0..R30.
  - inc = pend_set and pend_addr != ZERO_REG, applied to cnt[pend_addr].
  - dec = rf_we and rf_w_ld and rf_w_addr != ZERO_REG, applied to cnt[rf_w_addr].
  - inc and dec on the same register in the same cycle: counter unchanged. Different registers: both update.
  - Overflow (inc only, cnt == max): counter holds at max; sb_err set next edge.
  - Underflow (dec only, cnt == 0): counter holds at 0; sb_err set next edge.
  - sb_err clears only on reset.
  - A non-load write (rf_w_ld=0) never changes any counter.
- Busy:
  - busy(addr) = (cnt[addr] != 0) and not (dec this cycle to addr with cnt[addr] == 1 and no inc to addr this cycle).
  - So a consumer sees the load result via bypass and is released in the write-back cycle.
  - ZERO_REG is never busy.
- pend_set targeting ZERO_REG is a no-op; no error.

Decomposition:
- Shared package (beta_pkg): REG_ZERO = 5'd31, NUM_REGS = 31, SB_CNT_W, DATA_W.
- Sub-module rf_sb_counter: one saturating up/down counter with inc, dec, cnt, nonzero and err outputs. Instantiated NUM_REGS times from a generate loop; the per-instance err outputs are OR-reduced into sb_err.

Test Plan:
- Reset then read all: rst_n=0 async mid-cycle -> ra_data/rb_data = 0 for every address, all busy = 0, sb_err = 0.
- Write/read: rf_we=1, rf_w_addr=5, rf_w_data=32'hDEADBEEF; ra_addr=5 in the same cycle -> ra_data = DEADBEEF (bypass). Next cycle with rf_we=0 -> still DEADBEEF.
- Zero reg: rf_we=1, rf_w_addr=31, data=32'h1234 -> rb_addr=31 reads 0 in that cycle and the next; no stored register changes.
- Load scoreboard: pend_set, pend_addr=7 -> ra_addr=7 busy from the next cycle. Two cycles later rf_we=1, rf_w_ld=1, addr=7, data=32'hA5 -> ra_busy=0 and ra_data=A5 in that same cycle.
- Simultaneous inc/dec: cnt[3]=1; pend_set to 3 and load write to 3 in the same cycle -> rb_busy stays 1 that cycle and after, cnt[3] stays 1, rb_data shows the bypassed write.
- Error paths:
  - Four pend_set to 9 with no writes -> cnt[9] saturates at 3, sb_err=1 after the 4th edge.
  - After reset, load write to 12 with cnt=0 -> sb_err=1, cnt[12] stays 0.
